hazard_stall_ctrl: RTL and testbench

// - Pipeline sequencer for the 5-stage core. It drives the write-enables and flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// - Handles four cases: load-use hazards, taken-branch flushes, multi-cycle EX operations (MUL/DIV) and data-memory wait states.
// - Sits beside the ID/EX register. It reads decode-stage source registers and EX-stage control, and returns per-stage enables.

---
 rtl/hazard_stall_ctrl_pkg.sv | 37 +++
 rtl/hazard_stall_ctrl_sat_counter.sv | 23 ++
 rtl/hazard_stall_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer: FSM states,
// register-address width and the bundle of per-stage register controls.
package hazard_stall_ctrl_pkg;

   localparam int REG_AW = 5;

   typedef enum logic {
      RUN     = 1'b0,
      MC_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic pc_we;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_we;
      logic id_ex_bubble;
      logic ex_mem_we;
      logic mem_wb_we;
   } stage_ctrl_t;

   localparam stage_ctrl_t CTRL_RUN = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
      id_ex_we: 1'b1, id_ex_bubble: 1'b0, ex_mem_we: 1'b1, mem_wb_we: 1'b1};
   localparam stage_ctrl_t CTRL_RESET = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1,
      id_ex_we: 1'b0, id_ex_bubble: 1'b1, ex_mem_we: 1'b0, mem_wb_we: 1'b0};
   localparam stage_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
      id_ex_we: 1'b0, id_ex_bubble: 1'b0, ex_mem_we: 1'b0, mem_wb_we: 1'b0};
   // Older instructions drain through MEM/WB while EX holds the multi-cycle op.
   localparam stage_ctrl_t CTRL_MC_HOLD = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
      id_ex_we: 1'b0, id_ex_bubble: 1'b0, ex_mem_we: 1'b0, mem_wb_we: 1'b1};
   // IF/ID and ID/EX are written, but with a NOP and zeroed control respectively.
   localparam stage_ctrl_t CTRL_FLUSH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
      id_ex_we: 1'b1, id_ex_bubble: 1'b1, ex_mem_we: 1'b1, mem_wb_we: 1'b1};
   localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
      id_ex_we: 1'b1, id_ex_bubble: 1'b1, ex_mem_we: 1'b1, mem_wb_we: 1'b1};

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         q_q <= '0;
      end else if (inc && !(&q_q)) begin
         q_q <= q_q + W'(1);
      end
   end

   assign q = q_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer: decodes memory waits, multi-cycle EX ops, branch flushes
// and load-use hazards into per-stage write-enable / flush / bubble controls.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MC_LATENCY = 4,
   parameter int REG_AW     = hazard_stall_ctrl_pkg::REG_AW,
   parameter int PERF_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_branch_taken,
   input  logic              ex_mc_start,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_we,
   output logic              if_id_we,
   output logic              if_id_flush,
   output logic              id_ex_we,
   output logic              id_ex_bubble,
   output logic              ex_mem_we,
   output logic              mem_wb_we,
   output logic              mc_busy,
   output logic              mc_done,
   output logic [PERF_W-1:0] stall_cnt
);

   localparam int CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MC_LATENCY - 2);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   stage_ctrl_t       ctrl;
   logic              mem_stall;
   logic              load_use;

   assign mem_stall = mem_req & ~mem_ready;
   assign load_use  = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      ctrl    = CTRL_RUN;
      mc_done = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!rst_n) begin
         ctrl    = CTRL_RESET;
         state_d = RUN;
         cnt_d   = '0;
      end else if (mem_stall) begin
         // The multi-cycle unit keeps computing; only the exit waits for memory.
         ctrl = CTRL_FREEZE;
         if (state_q == MC_BUSY && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end else if (state_q == MC_BUSY) begin
         if (cnt_q != '0) begin
            ctrl  = CTRL_MC_HOLD;
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            mc_done = 1'b1;
            state_d = RUN;
         end
      end else if (ex_branch_taken) begin
         ctrl = CTRL_FLUSH;
      end else if (ex_mc_start) begin
         ctrl    = CTRL_MC_HOLD;
         state_d = MC_BUSY;
         cnt_d   = CNT_START;
      end else if (load_use) begin
         ctrl = CTRL_LOAD_USE;
      end
   end

   assign pc_we        = ctrl.pc_we;
   assign if_id_we     = ctrl.if_id_we;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_we     = ctrl.id_ex_we;
   assign id_ex_bubble = ctrl.id_ex_bubble;
   assign ex_mem_we    = ctrl.ex_mem_we;
   assign mem_wb_we    = ctrl.mem_wb_we;
   assign mc_busy      = rst_n & (state_q == MC_BUSY);

   sat_counter #(.W(PERF_W)) u_stall_cnt (
      .clk (clk),
      .inc (rst_n & ~ctrl.pc_we),
      .clr (~rst_n),
      .q   (stall_cnt)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level reference model of the stall rules.
module tb_hazard_stall_ctrl;

   localparam int LAT  = 4;
   localparam int AW   = 5;
   localparam int PW   = 4;
   localparam int SMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] id_rs1, id_rs2, ex_rd;
   logic          id_uses_rs2, ex_mem_read, ex_branch_taken, ex_mc_start;
   logic          mem_req, mem_ready;
   logic          pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
   logic          ex_mem_we, mem_wb_we, mc_busy, mc_done;
   logic [PW-1:0] stall_cnt;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state: whether a multi-cycle op occupies EX, how many
   // cycles have elapsed since its start cycle, and the stall-cycle tally.
   bit in_mc    = 0;
   int mc_age   = 0;
   int stalls   = 0;
   logic [6:0] exp_ctrl;
   logic       exp_busy, exp_done;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MC_LATENCY(LAT), .REG_AW(AW), .PERF_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we),
      .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_we(id_ex_we),
      .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
      .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Bit order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we
   task automatic model_eval();
      bit ms, lu;
      ms = mem_req && !mem_ready;
      lu = ex_mem_read && ex_rd != 0 &&
           (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
      exp_done = 1'b0;
      exp_busy = rst_n && in_mc;
      if (!rst_n)                   exp_ctrl = 7'b0010100;
      else if (ms)                  exp_ctrl = 7'b0000000;
      else if (in_mc) begin
         if (mc_age < LAT - 1)      exp_ctrl = 7'b0000001;
         else begin                 exp_ctrl = 7'b1101011; exp_done = 1'b1; end
      end
      else if (ex_branch_taken)     exp_ctrl = 7'b1111111;
      else if (ex_mc_start)         exp_ctrl = 7'b0000001;
      else if (lu)                  exp_ctrl = 7'b0001111;
      else                          exp_ctrl = 7'b1101011;
   endtask

   task automatic model_advance();
      bit ms;
      ms = mem_req && !mem_ready;
      if (!rst_n) begin
         in_mc  = 0;
         stalls = 0;
      end else begin
         if (!exp_ctrl[6] && stalls < SMAX) stalls++;
         if (in_mc) begin
            if (exp_done) in_mc = 0;
            else          mc_age++;
         end else if (!ms && !ex_branch_taken && ex_mc_start) begin
            in_mc  = 1;
            mc_age = 1;
         end
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic run_cycle(input string tag);
      #1;
      model_eval();
      chk(tag, {19'd0, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
                ex_mem_we, mem_wb_we, mc_busy, mc_done, stall_cnt},
               {19'd0, exp_ctrl, exp_busy, exp_done, PW'(stalls)});
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
      ex_branch_taken = 0; ex_mc_start = 0; mem_req = 0; mem_ready = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);

      // Reset state
      #1;
      chk("reset_ctrl", {25'd0, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
                         ex_mem_we, mem_wb_we}, 32'b0010100);
      chk("reset_busy_done", {30'd0, mc_busy, mc_done}, 32'd0);
      run_cycle("reset0");
      run_cycle("reset1");
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      rst_n = 1'b1;

      // Load-use on rs1
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
      #1;
      chk("loaduse_stall", {29'd0, pc_we, if_id_we, id_ex_bubble}, 32'b001);
      run_cycle("loaduse");
      ex_mem_read = 0; ex_rd = 9; id_rs1 = 3;
      #1;
      chk("loaduse_one_bubble", {30'd0, pc_we, id_ex_bubble}, 32'b10);
      chk("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);
      run_cycle("after_loaduse");

      // Register 0 guard
      ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
      #1;
      chk("reg0_no_stall", {25'd0, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
                            ex_mem_we, mem_wb_we}, 32'b1101011);
      run_cycle("reg0");
      idle_inputs();

      // Multi-cycle op: frozen T0..T2, done at T3, idle at T4
      ex_mc_start = 1;
      for (int t = 0; t < LAT - 1; t++) begin
         #1;
         chk($sformatf("mc_frozen_T%0d", t), 32'(pc_we), 32'd0);
         run_cycle($sformatf("mc_T%0d", t));
      end
      #1;
      chk("mc_done_T3", {30'd0, mc_done, pc_we}, 32'b11);
      run_cycle("mc_T3");
      ex_mc_start = 0;
      #1;
      chk("mc_idle_T4", {30'd0, mc_busy, mc_done}, 32'd0);
      run_cycle("mc_T4");

      // Branch deferred by a memory stall
      ex_branch_taken = 1; mem_req = 1; mem_ready = 0;
      for (int t = 0; t < 2; t++) begin
         #1;
         chk($sformatf("br_stalled_%0d", t), {25'd0, pc_we, if_id_we, if_id_flush, id_ex_we,
                                              id_ex_bubble, ex_mem_we, mem_wb_we}, 32'd0);
         run_cycle($sformatf("br_stall_%0d", t));
      end
      mem_ready = 1;
      #1;
      chk("br_flush", {29'd0, if_id_flush, id_ex_bubble, pc_we}, 32'b111);
      run_cycle("br_release");
      idle_inputs();

      // Reset while MC_BUSY with cnt=1
      ex_mc_start = 1;
      run_cycle("mcr_T0");
      run_cycle("mcr_T1");
      rst_n = 0;
      run_cycle("mcr_T2_reset");
      rst_n = 1; ex_mc_start = 0;
      #1;
      chk("mcr_aborted", {28'd0, mc_busy, mc_done, 2'b00}, 32'd0);
      chk("mcr_stall_cnt", 32'(stall_cnt), 32'd0);
      run_cycle("mcr_after");

      // Saturation of the stall counter
      mem_req = 1; mem_ready = 0;
      for (int t = 0; t < 20; t++) run_cycle("sat_hold");
      #1;
      chk("sat_cnt", 32'(stall_cnt), 32'(SMAX));
      idle_inputs();
      run_cycle("sat_release");

      // Randomized traffic; branch and mc_start are never raised together
      for (int n = 0; n < 600; n++) begin
         rst_n           = ($urandom_range(0, 99) != 0);
         id_rs1          = AW'($urandom_range(0, 3));
         id_rs2          = AW'($urandom_range(0, 3));
         ex_rd           = AW'($urandom_range(0, 3));
         id_uses_rs2     = 1'($urandom_range(0, 1));
         ex_mem_read     = 1'($urandom_range(0, 1));
         mem_req         = ($urandom_range(0, 9) < 3);
         mem_ready       = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 9) == 0);
         ex_mc_start     = !ex_branch_taken && ($urandom_range(0, 9) == 0);
         run_cycle("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
